strided_window_addr_gen: RTL and testbench
==========================================

// Module: strided_window_addr_gen
// PURPOSE
//  Next-gen strided conv-window read-address generator for the banked feature-map buffer (N_BUF_X column banks).
//  Walks every output position (x,y) at a given stride and every kernel tap (dx,dy) and channel wrap (dc).
//  Emits per-bank read addresses, bank select and a pad flag, over a valid/ready handshake with start/done control.
//  Additions over the previous generation: handshake, start/done, base pointer, config-error detection, full parametrisation.
// PARAMETERS
//  N_BUF_X     10  number of column banks; column c lives in bank c%N_BUF_X at row-block c/N_BUF_X
//  B_BUF_ADDR  9   bank address width; all address arithmetic is modulo 2^B_BUF_ADDR
//  B_COORD     9   width of ftm/wei width/height fields
//  B_CWRAP     7   width of n_wrap_c (channel words per pixel)
//  B_STRIDE    2   stride/pad width; stride must be in [1, N_BUF_X-1]
// PORTS
//  clk        in   1                   clock
//  rst        in   1                   synchronous, active-high reset
//  start      in   1                   start pulse; config sampled when start=1 in IDLE, ignored otherwise
//  stride     in   B_STRIDE            window step in x and y
//  pad        in   B_STRIDE            zero padding on each of the four sides
//  w_ftm,h_ftm in  B_COORD             feature-map width/height (unpadded)
//  w_wei,h_wei in  B_COORD             kernel width/height
//  n_wrap_c   in   B_CWRAP             channel words per pixel, >=1
//  base_addr  in   B_BUF_ADDR          buffer address of pixel (0,0), dc=0
//  out_valid  out  1                   element on rd_* is valid
//  out_ready  in   1                   consumer accepts element
//  rd_addr    out  N_BUF_X*B_BUF_ADDR  per-bank address; only the selected bank is nonzero
//  rd_sel     out  $clog2(N_BUF_X+1)   bank index; N_BUF_X means padding (consumer outputs zero)
//  rd_pad     out  1                   element lies in the padded region
//  rd_last    out  1                   final element of the sweep
//  busy       out  1                   high in RUN
//  done       out  1                   one-cycle pulse at sweep end
//  cfg_err    out  1                   latched on bad config; cleared by next accepted start
//  next_base  out  B_BUF_ADDR          base_addr + n_wrap_c*h_ftm*ceil(w_ftm/N_BUF_X), valid once done has pulsed
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, rd_pad, rd_last, busy, done and cfg_err=0; rd_addr=0, rd_sel=0, next_base=0.
//  FSM IDLE->RUN on start when config is legal; IDLE->IDLE with cfg_err=1 and done pulse when illegal.
//    Illegal: any of w_ftm,h_ftm,w_wei,h_wei,n_wrap_c,stride is 0; w_wei>w_ftm+2*pad; h_wei>h_ftm+2*pad.
//    RUN->IDLE on the handshake of the rd_last element; done pulses the following cycle.
//  Latency: start at edge k -> first element has out_valid=1 after edge k+1. The element advances only when out_valid&&out_ready.
//    While stalled, all rd_* outputs are held stable. There are no bubbles while out_ready=1 (1 element/cycle).
//  Loop order, inner->outer: dc 0..n_wrap_c-1, dy 0..h_wei-1, dx 0..w_wei-1, y 0,stride,.. , x 0,stride,..
//    Padded-space coordinates are X=x+dx, Y=y+dy. The y loop ends when y+stride > h_ftm+2*pad-h_wei; x uses the same rule with w_ftm/w_wei.
//  Pad test: X<pad | X>=w_ftm+pad | Y<pad | Y>=h_ftm+pad -> rd_pad=1, rd_sel=N_BUF_X, rd_addr all zero.
//  Otherwise c=X-pad, r=Y-pad: rd_sel=c%N_BUF_X.
//    addr=base_addr+n_wrap_c*((c/N_BUF_X)*h_ftm+r)+dc, truncated to B_BUF_ADDR, is driven on slice rd_sel; all other slices are 0.
//  No dividers: bank/row-block tracked incrementally; one x-step wraps the bank at most once (stride<N_BUF_X).
//  rd_last=1 only when dc,dy,dx are at their limits and x,y are both at the final position.
//  rst in RUN: next cycle IDLE, out_valid=0, no done pulse, partial sweep discarded.
// TESTING
//  T1 4x4 ftm, 3x3 wei, stride1 pad0, n_wrap_c=1, base=0, ready=1 -> 36 elements; first addr0/sel0; rd_last on 36th; done; next_base=4
//  T2 same as T1 with pad=1 -> 144 elements; element0 rd_pad=1, rd_sel=10, rd_addr=0; element4 (X=1,Y=1) sel0 addr0
//  T3 T1 with out_ready random 50% -> element sequence identical to T1; rd_* stable on every stalled cycle
//  T4 w_ftm=12,h_ftm=3,1x1 wei,n_wrap_c=2,base=5 -> column 10: sel0, addr=5+2*(3+y)+dc; next_base=5+2*3*2=17
//  T5 5x5 ftm, 3x3, stride2 -> x,y in {0,2}, 36 elements; rst at element 10 -> out_valid=0 and busy=0 next cycle, no done
//  T6 w_wei=5,w_ftm=3,pad0 start -> cfg_err=1, done pulse, no out_valid; legal start afterwards clears cfg_err

Source files
------------

// File: rtl/strided_window_addr_gen_if.sv
// Read-element stream from the window address generator to the banked buffer.
// The generator owns valid and the rd_* payload; the consumer owns ready.
interface strided_window_addr_gen_if #(
    parameter int N_BUF_X    = 10,
    parameter int B_BUF_ADDR = 9
);
    localparam int SEL_W = $clog2(N_BUF_X + 1);

    logic                          out_valid;
    logic                          out_ready;
    logic [N_BUF_X*B_BUF_ADDR-1:0] rd_addr;
    logic [SEL_W-1:0]              rd_sel;
    logic                          rd_pad;
    logic                          rd_last;

    modport master (
        output out_valid, rd_addr, rd_sel, rd_pad, rd_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, rd_addr, rd_sel, rd_pad, rd_last,
        output out_ready
    );
endinterface

// File: rtl/strided_window_addr_gen.sv
// Strided conv-window read-address generator for a column-banked feature-map buffer.
// Walks x, y, dx, dy, dc (outer to inner) and emits one bank address per accepted element.
module strided_window_addr_gen #(
    parameter int N_BUF_X    = 10,
    parameter int B_BUF_ADDR = 9,
    parameter int B_COORD    = 9,
    parameter int B_CWRAP    = 7,
    parameter int B_STRIDE   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [B_STRIDE-1:0]       stride,
    input  logic [B_STRIDE-1:0]       pad,
    input  logic [B_COORD-1:0]        w_ftm,
    input  logic [B_COORD-1:0]        h_ftm,
    input  logic [B_COORD-1:0]        w_wei,
    input  logic [B_COORD-1:0]        h_wei,
    input  logic [B_CWRAP-1:0]        n_wrap_c,
    input  logic [B_BUF_ADDR-1:0]     base_addr,
    strided_window_addr_gen_if.master rd,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err,
    output logic [B_BUF_ADDR-1:0]     next_base
);
    localparam int SEL_W   = $clog2(N_BUF_X + 1);
    localparam int SW1     = SEL_W + 1;
    localparam int PW      = B_COORD + 2;
    localparam int W2      = B_COORD + 3;
    localparam int MAX_BLK = ((1 << B_COORD) + N_BUF_X - 2) / N_BUF_X;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;

    logic accept_start, reject_start, finish, load;
    logic cfg_legal;
    logic [B_COORD-1:0] blocks_in;

    logic [B_STRIDE-1:0]   stride_r, pad_r;
    logic [B_COORD-1:0]    w_ftm_r, h_ftm_r, w_wei_r, h_wei_r, blocks_r;
    logic [B_CWRAP-1:0]    n_wrap_r;
    logic [B_BUF_ADDR-1:0] base_r, blk_step_r;

    logic [PW-1:0]      x_r, y_r;
    logic [B_COORD-1:0] dx_r, dy_r;
    logic [B_CWRAP-1:0] dc_r;
    logic [SEL_W-1:0]   ox_bank, cx_bank;
    logic [B_COORD-1:0] ox_blk, cx_blk;
    logic               gen_pending;

    logic                          valid_q, last_q, pad_q;
    logic [SEL_W-1:0]              sel_q;
    logic [N_BUF_X*B_BUF_ADDR-1:0] addr_q;

    logic dc_last, dy_last, dx_last, y_last, x_last, elem_last;
    logic [PW-1:0]                 px, py;
    logic                          is_pad;
    logic [B_COORD-1:0]            row, blk;
    logic [SEL_W-1:0]              bank, elem_sel;
    logic [B_BUF_ADDR-1:0]         elem_addr;
    logic [N_BUF_X*B_BUF_ADDR-1:0] elem_flat;
    logic [SW1-1:0]                ox_sum;
    logic [SEL_W-1:0]              ox_bank_nxt;
    logic [B_COORD-1:0]            ox_blk_nxt;

    assign rd.out_valid = valid_q;
    assign rd.rd_last   = last_q;
    assign rd.rd_pad    = pad_q;
    assign rd.rd_sel    = sel_q;
    assign rd.rd_addr   = addr_q;
    assign busy         = (state == RUN);

    // Config legality and the column-block count, built from constant comparators instead of a divider.
    always_comb begin
        cfg_legal = (w_ftm != '0) && (h_ftm != '0) && (w_wei != '0) && (h_wei != '0) &&
                    (n_wrap_c != '0) && (stride != '0) &&
                    (W2'(w_wei) <= W2'(w_ftm) + (W2'(pad) << 1)) &&
                    (W2'(h_wei) <= W2'(h_ftm) + (W2'(pad) << 1));
        blocks_in = '0;
        for (int k = 0; k < MAX_BLK; k++) begin
            if (int'(w_ftm) > k * N_BUF_X) begin
                blocks_in = blocks_in + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        reject_start = 1'b0;
        finish       = 1'b0;
        load         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_legal) begin
                        state_next   = RUN;
                        accept_start = 1'b1;
                    end else begin
                        reject_start = 1'b1;
                    end
                end
            end
            RUN: begin
                load = gen_pending && (!valid_q || rd.out_ready);
                if (valid_q && rd.out_ready && last_q) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Loop-limit tests, done in a wider width so the padded extent never underflows.
    always_comb begin
        dc_last   = (dc_r == n_wrap_r - 1'b1);
        dy_last   = (dy_r == h_wei_r - 1'b1);
        dx_last   = (dx_r == w_wei_r - 1'b1);
        y_last    = (W2'(y_r) + W2'(stride_r) + W2'(h_wei_r)) > (W2'(h_ftm_r) + (W2'(pad_r) << 1));
        x_last    = (W2'(x_r) + W2'(stride_r) + W2'(w_wei_r)) > (W2'(w_ftm_r) + (W2'(pad_r) << 1));
        elem_last = dc_last && dy_last && dx_last && y_last && x_last;

        ox_sum = SW1'(ox_bank) + SW1'(stride_r);
        if (ox_sum >= SW1'(N_BUF_X)) begin
            ox_bank_nxt = SEL_W'(ox_sum - SW1'(N_BUF_X));
            ox_blk_nxt  = ox_blk + 1'b1;
        end else begin
            ox_bank_nxt = SEL_W'(ox_sum);
            ox_blk_nxt  = ox_blk;
        end
    end

    // The tracked column is in padded space; shifting it back by pad borrows one block when the bank underflows.
    always_comb begin
        px     = x_r + PW'(dx_r);
        py     = y_r + PW'(dy_r);
        is_pad = (px < PW'(pad_r)) || (px >= PW'(w_ftm_r) + PW'(pad_r)) ||
                 (py < PW'(pad_r)) || (py >= PW'(h_ftm_r) + PW'(pad_r));
        row    = B_COORD'(py - PW'(pad_r));
        if (cx_bank >= SEL_W'(pad_r)) begin
            bank = cx_bank - SEL_W'(pad_r);
            blk  = cx_blk;
        end else begin
            bank = cx_bank + SEL_W'(N_BUF_X) - SEL_W'(pad_r);
            blk  = cx_blk - 1'b1;
        end
        elem_addr = base_r + B_BUF_ADDR'(blk) * blk_step_r +
                    B_BUF_ADDR'(n_wrap_r) * B_BUF_ADDR'(row) + B_BUF_ADDR'(dc_r);
        elem_sel  = is_pad ? SEL_W'(N_BUF_X) : bank;
        elem_flat = '0;
        for (int i = 0; i < N_BUF_X; i++) begin
            if (!is_pad && (bank == SEL_W'(i))) begin
                elem_flat[i*B_BUF_ADDR +: B_BUF_ADDR] = elem_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_r    <= '0;
            pad_r       <= '0;
            w_ftm_r     <= '0;
            h_ftm_r     <= '0;
            w_wei_r     <= '0;
            h_wei_r     <= '0;
            n_wrap_r    <= '0;
            base_r      <= '0;
            blk_step_r  <= '0;
            blocks_r    <= '0;
            x_r         <= '0;
            y_r         <= '0;
            dx_r        <= '0;
            dy_r        <= '0;
            dc_r        <= '0;
            ox_bank     <= '0;
            ox_blk      <= '0;
            cx_bank     <= '0;
            cx_blk      <= '0;
            gen_pending <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            pad_q       <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            next_base   <= '0;
        end else begin
            done <= 1'b0;
            if (accept_start) begin
                stride_r    <= stride;
                pad_r       <= pad;
                w_ftm_r     <= w_ftm;
                h_ftm_r     <= h_ftm;
                w_wei_r     <= w_wei;
                h_wei_r     <= h_wei;
                n_wrap_r    <= n_wrap_c;
                base_r      <= base_addr;
                blk_step_r  <= B_BUF_ADDR'(n_wrap_c) * B_BUF_ADDR'(h_ftm);
                blocks_r    <= blocks_in;
                x_r         <= '0;
                y_r         <= '0;
                dx_r        <= '0;
                dy_r        <= '0;
                dc_r        <= '0;
                ox_bank     <= '0;
                ox_blk      <= '0;
                cx_bank     <= '0;
                cx_blk      <= '0;
                gen_pending <= 1'b1;
                cfg_err     <= 1'b0;
            end
            if (reject_start) begin
                cfg_err <= 1'b1;
                done    <= 1'b1;
            end
            if (finish) begin
                done      <= 1'b1;
                next_base <= base_r + B_BUF_ADDR'(blocks_r) * blk_step_r;
            end
            if (load) begin
                valid_q <= 1'b1;
                last_q  <= elem_last;
                pad_q   <= is_pad;
                sel_q   <= elem_sel;
                addr_q  <= elem_flat;
                if (elem_last) begin
                    gen_pending <= 1'b0;
                end
                if (!dc_last) begin
                    dc_r <= dc_r + 1'b1;
                end else begin
                    dc_r <= '0;
                    if (!dy_last) begin
                        dy_r <= dy_r + 1'b1;
                    end else begin
                        dy_r <= '0;
                        if (!dx_last) begin
                            dx_r <= dx_r + 1'b1;
                            if (cx_bank == SEL_W'(N_BUF_X - 1)) begin
                                cx_bank <= '0;
                                cx_blk  <= cx_blk + 1'b1;
                            end else begin
                                cx_bank <= cx_bank + 1'b1;
                            end
                        end else begin
                            dx_r <= '0;
                            if (!y_last) begin
                                y_r     <= y_r + PW'(stride_r);
                                cx_bank <= ox_bank;
                                cx_blk  <= ox_blk;
                            end else begin
                                y_r     <= '0;
                                x_r     <= x_r + PW'(stride_r);
                                ox_bank <= ox_bank_nxt;
                                ox_blk  <= ox_blk_nxt;
                                cx_bank <= ox_bank_nxt;
                                cx_blk  <= ox_blk_nxt;
                            end
                        end
                    end
                end
            end else if (rd.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_strided_window_addr_gen.sv
// Scoreboard bench for strided_window_addr_gen: a loop-nest reference model fills a queue at start,
// and every accepted element is popped and compared.
module tb_strided_window_addr_gen;
    localparam int NB = 10;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    stride, pad;
    logic [8:0]    w_ftm, h_ftm, w_wei, h_wei;
    logic [6:0]    n_wrap_c;
    logic [AW-1:0] base_addr;
    logic          busy, done, cfg_err;
    logic [AW-1:0] next_base;

    int checks = 0;
    int errors = 0;
    int elem_cnt = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    bit rand_ready = 1'b0;
    logic [95:0] exp_q[$];

    logic [95:0] cur;
    logic [96:0] held;
    bit          stall_hold = 1'b0;

    strided_window_addr_gen_if #(.N_BUF_X(NB), .B_BUF_ADDR(AW)) bus ();

    strided_window_addr_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stride    (stride),
        .pad       (pad),
        .w_ftm     (w_ftm),
        .h_ftm     (h_ftm),
        .w_wei     (w_wei),
        .h_wei     (h_wei),
        .n_wrap_c  (n_wrap_c),
        .base_addr (base_addr),
        .rd        (bus),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .next_base (next_base)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic build_expected(input int st, input int pd, input int wf, input int hf,
                                  input int ww, input int hw, input int nw, input int bs);
        int wp, hp;
        logic [95:0] e;
        wp = wf + 2 * pd;
        hp = hf + 2 * pd;
        for (int x = 0; x + ww <= wp; x += st)
            for (int y = 0; y + hw <= hp; y += st)
                for (int dx = 0; dx < ww; dx++)
                    for (int dy = 0; dy < hw; dy++)
                        for (int dc = 0; dc < nw; dc++) begin
                            int px, py, c, r, sel, ad;
                            bit p;
                            logic [NB*AW-1:0] a;
                            px = x + dx;
                            py = y + dy;
                            a = '0;
                            p = (px < pd) || (px >= wf + pd) || (py < pd) || (py >= hf + pd);
                            if (p) begin
                                sel = NB;
                            end else begin
                                c = px - pd;
                                r = py - pd;
                                sel = c % NB;
                                ad = (bs + nw * ((c / NB) * hf + r) + dc) % (1 << AW);
                                a[sel*AW +: AW] = ad[AW-1:0];
                            end
                            exp_q.push_back({a, 4'(sel), p, 1'b0});
                        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_back();
            e[0] = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int st, input int pd, input int wf, input int hf,
                                 input int ww, input int hw, input int nw, input int bs, input bit legal);
        @(posedge clk);
        #1;
        stride    = 2'(st);
        pad       = 2'(pd);
        w_ftm     = 9'(wf);
        h_ftm     = 9'(hf);
        w_wei     = 9'(ww);
        h_wei     = 9'(hw);
        n_wrap_c  = 7'(nw);
        base_addr = AW'(bs);
        start     = 1'b1;
        if (legal) build_expected(st, pd, wf, hf, ww, hw, nw, bs);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_sweep(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) checkOutput("sweep_timeout", done_cnt, d0 + 1);
        repeat (4) @(negedge clk);
        checkOutput("done_pulses", done_cnt - d0, 1);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("busy_after", busy, 0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        cur = {bus.rd_addr, bus.rd_sel, bus.rd_pad, bus.rd_last};
        if (rst) begin
            stall_hold = 1'b0;
        end else begin
            if (bus.out_valid) valid_cnt++;
            if (done) done_cnt++;
            if (stall_hold) checkOutput("stall_hold", {bus.out_valid, cur}, held);
            stall_hold = bus.out_valid && !bus.out_ready;
            held = {bus.out_valid, cur};
            if (bus.out_valid && bus.out_ready) begin
                elem_cnt++;
                if (exp_q.size() == 0) checkOutput("unexpected_elem", exp_q.size(), 1);
                else checkOutput($sformatf("elem%0d", elem_cnt), cur, exp_q.pop_front());
            end
        end
    end

    initial begin
        int d0, e0, v0, n;
        rst = 1'b1;
        start = 1'b0;
        stride = '0;
        pad = '0;
        w_ftm = '0;
        h_ftm = '0;
        w_wei = '0;
        h_wei = '0;
        n_wrap_c = '0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", bus.out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_addr", bus.rd_addr, 0);
        checkOutput("rst_sel", bus.rd_sel, 0);
        checkOutput("rst_pad_last", {bus.rd_pad, bus.rd_last}, 0);
        checkOutput("rst_next_base", next_base, 0);

        $display("[TB] T1 4x4 ftm 3x3 wei stride1 pad0");
        d0 = done_cnt; e0 = elem_cnt;
        applyStimulus(1, 0, 4, 4, 3, 3, 1, 0, 1);
        @(negedge clk);
        checkOutput("t1_lat_valid0", bus.out_valid, 0);
        checkOutput("t1_lat_busy", busy, 1);
        @(negedge clk);
        checkOutput("t1_lat_valid1", bus.out_valid, 1);
        wait_sweep(d0);
        checkOutput("t1_count", elem_cnt - e0, 36);
        checkOutput("t1_next_base", next_base, 4);
        checkOutput("t1_cfg_err", cfg_err, 0);

        $display("[TB] T2 pad1");
        d0 = done_cnt; e0 = elem_cnt;
        applyStimulus(1, 1, 4, 4, 3, 3, 1, 0, 1);
        wait_sweep(d0);
        checkOutput("t2_count", elem_cnt - e0, 144);
        checkOutput("t2_next_base", next_base, 4);

        $display("[TB] T3 random ready");
        rand_ready = 1'b1;
        d0 = done_cnt; e0 = elem_cnt;
        applyStimulus(1, 0, 4, 4, 3, 3, 1, 0, 1);
        wait_sweep(d0);
        checkOutput("t3_count", elem_cnt - e0, 36);
        rand_ready = 1'b0;

        $display("[TB] T4 two row-blocks, n_wrap_c=2, base=5");
        d0 = done_cnt; e0 = elem_cnt;
        applyStimulus(1, 0, 12, 3, 1, 1, 2, 5, 1);
        wait_sweep(d0);
        checkOutput("t4_count", elem_cnt - e0, 72);
        checkOutput("t4_next_base", next_base, 17);

        $display("[TB] T5 stride2, reset mid-sweep");
        d0 = done_cnt; e0 = elem_cnt;
        applyStimulus(2, 0, 5, 5, 3, 3, 1, 0, 1);
        n = 0;
        while (elem_cnt - e0 < 10 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t5_reach10", (elem_cnt - e0 >= 10), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_valid", bus.out_valid, 0);
        checkOutput("t5_rst_busy", busy, 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        checkOutput("t5_no_done", done_cnt - d0, 0);
        checkOutput("t5_next_base", next_base, 0);

        $display("[TB] T6 illegal config then legal start");
        d0 = done_cnt; v0 = valid_cnt;
        applyStimulus(1, 0, 3, 3, 5, 3, 1, 0, 0);
        repeat (4) @(negedge clk);
        checkOutput("t6_cfg_err", cfg_err, 1);
        checkOutput("t6_done", done_cnt - d0, 1);
        checkOutput("t6_no_valid", valid_cnt - v0, 0);
        checkOutput("t6_busy", busy, 0);
        d0 = done_cnt; e0 = elem_cnt;
        applyStimulus(1, 0, 4, 4, 3, 3, 1, 0, 1);
        @(negedge clk);
        checkOutput("t6_cfg_clr", cfg_err, 0);
        wait_sweep(d0);
        checkOutput("t6_count", elem_cnt - e0, 36);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
